// File: rtl/shiftcomp_seq_pkg.sv
// shiftcomp_pkg
// Shared types and constants for the shift-and-compare sequencer:
//   state_t  : sequencer FSM states (IDLE, LOAD, RUN, DONE)
//   status_t : 2-bit result code carried on res_status
//   ST_HIT / ST_TIMEOUT / ST_ABORT : the result codes
// The timeout exit is controlled by the macro SHIFTCOMP_SEQ_TIMEOUT_EN,
// which is tested only inside shiftcomp_seq_cnt.
package shiftcomp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_HIT     = 2'd0;
  localparam status_t ST_TIMEOUT = 2'd1;
  localparam status_t ST_ABORT   = 2'd2;

endpackage

// File: rtl/shiftcomp_seq_if.sv
// shiftcomp_seq_if
// Command and result handshake bundle of the sequencer.
//   start_valid / start_ready : command handshake (master -> sequencer)
//   cmd_init / cmd_test       : search command payload
//   res_valid / res_ready     : result handshake (sequencer -> master)
//   res_count / res_status    : result payload
// Modports: master = command master side, slave = sequencer side.
interface shiftcomp_seq_if
  import shiftcomp_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 5
);

  logic             start_valid;
  logic             start_ready;
  logic [W-1:0]     cmd_init;
  logic [W-1:0]     cmd_test;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  status_t          res_status;

  modport master (
    output start_valid, cmd_init, cmd_test, res_ready,
    input  start_ready, res_valid, res_count, res_status
  );

  modport slave (
    input  start_valid, cmd_init, cmd_test, res_ready,
    output start_ready, res_valid, res_count, res_status
  );

endinterface

// File: rtl/shiftcomp_seq_cnt.sv
// shiftcomp_seq_cnt
// Clear/enable saturating up-counter used to count RUN cycles.
//   clk, rst (sync, active-low) : clock and reset
//   clear : force count to 0 (wins over en)
//   en    : increment, saturating at all-ones
//   count : current count
//   tc    : timeout terminal count (count == MAX_CYCLES-1)
// Macro SHIFTCOMP_SEQ_TIMEOUT_EN: when undefined, tc is tied low and no
// timeout compare is built; the counter then only saturates.
module shiftcomp_seq_cnt #(
  parameter int MAX_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  if (MAX_CYCLES < 1 || MAX_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("shiftcomp_seq_cnt: MAX_CYCLES must be >= 1 and < 2**CNT_W");
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (en && count != '1) begin
      count <= count + 1'b1;
    end
  end

`ifdef SHIFTCOMP_SEQ_TIMEOUT_EN
  assign tc = (count == CNT_W'(MAX_CYCLES - 1));
`else
  assign tc = 1'b0;
`endif

endmodule

// File: rtl/shiftcomp_seq.sv
// shiftcomp_seq
// Sequencer for one shifter/comparator pair: accepts {init, test}, loads
// the shifter, counts free-running RUN cycles until limit (HIT), abort
// (ABORT) or, with SHIFTCOMP_SEQ_TIMEOUT_EN defined, MAX_CYCLES (TIMEOUT),
// then presents {count, status} on a valid/ready result port.
//   clk, rst (sync, active-low)
//   bus     : shiftcomp_seq_if.slave (command and result handshakes)
//   abort   : terminate the current search (RUN only)
//   sc_load : shifter load strobe, sc_init : shifter load data
//   sc_test : comparator operand, limit : comparator equality result
module shiftcomp_seq
  import shiftcomp_pkg::*;
#(
  parameter int W          = 8,
  parameter int MAX_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  shiftcomp_seq_if.slave       bus,
  input  logic                 abort,
  output logic                 sc_load,
  output logic [W-1:0]         sc_init,
  output logic [W-1:0]         sc_test,
  input  logic                 limit
);

  state_t           state, state_next;
  logic [W-1:0]     init_q, test_q;
  logic [CNT_W-1:0] res_count_q, res_count_next;
  status_t          res_status_q, res_status_next;
  logic             capture, res_load, cnt_clear, cnt_en, tc;
  logic [CNT_W-1:0] count;

  shiftcomp_seq_cnt #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      init_q       <= '0;
      test_q       <= '0;
      res_count_q  <= '0;
      res_status_q <= ST_HIT;
    end else begin
      state <= state_next;
      if (capture) begin
        init_q <= bus.cmd_init;
        test_q <= bus.cmd_test;
      end
      if (res_load) begin
        res_count_q  <= res_count_next;
        res_status_q <= res_status_next;
      end
    end
  end

  // RUN exit priority: limit, then abort, then timeout. The counter keeps
  // incrementing on the exit edge, so the result is latched from count here.
  always_comb begin
    state_next      = state;
    capture         = 1'b0;
    res_load        = 1'b0;
    cnt_clear       = 1'b0;
    cnt_en          = 1'b0;
    res_count_next  = count;
    res_status_next = ST_HIT;
    case (state)
      IDLE: begin
        if (bus.start_valid) begin
          capture    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_clear  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        cnt_en = 1'b1;
        if (limit) begin
          res_load   = 1'b1;
          state_next = DONE;
        end else if (abort) begin
          res_load        = 1'b1;
          res_status_next = ST_ABORT;
          state_next      = DONE;
        end else if (tc) begin
          res_load        = 1'b1;
          res_count_next  = CNT_W'(MAX_CYCLES);
          res_status_next = ST_TIMEOUT;
          state_next      = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced to 0 while rst is low, so nothing leaks out during
  // reset; start_ready comes back in the first cycle rst is high.
  assign bus.start_ready = rst && (state == IDLE);
  assign bus.res_valid   = rst && (state == DONE);
  assign bus.res_count   = rst ? res_count_q  : '0;
  assign bus.res_status  = rst ? res_status_q : ST_HIT;
  assign sc_load         = rst && (state == LOAD);
  assign sc_init         = rst ? init_q : '0;
  assign sc_test         = rst ? test_q : '0;

endmodule

// File: tb/tb_shiftcomp_seq.sv
// tb_shiftcomp_seq
// Directed bench for shiftcomp_seq with a rotate-left shifter model and a
// scoreboard: each command pushes its expected {count, status}; a monitor
// pops and compares the first time each result is presented.
// Honours SHIFTCOMP_SEQ_TIMEOUT_EN for the no-match case.
module tb_shiftcomp_seq;
  import shiftcomp_pkg::*;

  localparam int W          = 8;
  localparam int MAX_CYCLES = 16;
  localparam int CNT_W      = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         abort = 1'b0;
  logic         sc_load;
  logic [W-1:0] sc_init, sc_test;
  logic         limit;
  logic [W-1:0] q = '0;

  int total = 0;
  int fails = 0;
  logic [CNT_W+1:0] exp_q[$];
  bit seen = 1'b0;

  shiftcomp_seq_if #(.W(W), .CNT_W(CNT_W)) bus ();

  shiftcomp_seq #(.W(W), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .abort   (abort),
    .sc_load (sc_load),
    .sc_init (sc_init),
    .sc_test (sc_test),
    .limit   (limit)
  );

  always #5 clk = ~clk;

  // Shifter/comparator model: load on sc_load, else rotate left by one.
  always @(posedge clk) begin
    if (sc_load) q <= sc_init;
    else         q <= {q[W-2:0], q[W-1]};
  end
  assign limit = (q == sc_test);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare each presented result exactly once.
  always @(negedge clk) begin
    if (rst && bus.res_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        total++;
        fails++;
        $display("[TB] FAIL spurious_result: got count 0x%0h status %0d, expected none",
                 bus.res_count, bus.res_status);
      end else begin
        logic [CNT_W+1:0] e;
        e = exp_q.pop_front();
        checkOutput("res_count", 32'(bus.res_count), 32'(e[CNT_W+1:2]));
        checkOutput("res_status", 32'(bus.res_status), 32'(e[1:0]));
      end
    end
    if (!bus.res_valid) seen = 1'b0;
  end

  // Called at a negedge; returns at the negedge of the LOAD cycle.
  task automatic sendCmd(input logic [W-1:0] init_v, input logic [W-1:0] test_v);
    int n = 0;
    bus.start_valid = 1'b1;
    bus.cmd_init    = init_v;
    bus.cmd_test    = test_v;
    while (!bus.start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.start_ready) begin
      checkOutput("start_ready_timeout", 32'(bus.start_ready), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    checkOutput("sc_load", 32'(sc_load), 32'd1);
    checkOutput("sc_init", 32'(sc_init), 32'(init_v));
    checkOutput("sc_test", 32'(sc_test), 32'(test_v));
  endtask

  task automatic applyStimulus(input logic [W-1:0] init_v, input logic [W-1:0] test_v,
                               input int exp_count, input status_t exp_status);
    exp_q.push_back({CNT_W'(exp_count), exp_status});
    sendCmd(init_v, test_v);
  endtask

  // Counts negedges from the current one until res_valid is seen.
  task automatic waitValid(output int n);
    n = 0;
    while (!bus.res_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) checkOutput("res_valid_timeout", 32'(bus.res_valid), 32'd1);
  endtask

  // From the LOAD negedge, raise abort during RUN count c for one cycle.
  task automatic abortAt(input int c);
    repeat (c + 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_start_ready"}, 32'(bus.start_ready), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    checkOutput({tag, "_sc_load"}, 32'(sc_load), 32'd0);
    checkOutput({tag, "_sc_init"}, 32'(sc_init), 32'd0);
    checkOutput({tag, "_sc_test"}, 32'(sc_test), 32'd0);
    checkOutput({tag, "_res_count"}, 32'(bus.res_count), 32'd0);
    checkOutput({tag, "_res_status"}, 32'(bus.res_status), 32'd0);
  endtask

  initial begin
    int n;
    bus.start_valid = 1'b0;
    bus.cmd_init    = '0;
    bus.cmd_test    = '0;
    bus.res_ready   = 1'b1;

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    #1 checkOutput("start_ready_after_reset", 32'(bus.start_ready), 32'd1);
    @(negedge clk);

    $display("[TB] basic match");
    applyStimulus(8'h01, 8'h08, 3, ST_HIT);
    waitValid(n);
    checkOutput("basic_latency", 32'(n), 32'd5);
    @(negedge clk);

    $display("[TB] immediate match with backpressure");
    bus.res_ready = 1'b0;
    applyStimulus(8'hA5, 8'hA5, 0, ST_HIT);
    waitValid(n);
    checkOutput("immediate_latency", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_res_valid", 32'(bus.res_valid), 32'd1);
      checkOutput("hold_res_count", 32'(bus.res_count), 32'd0);
      checkOutput("hold_res_status", 32'(bus.res_status), 32'(ST_HIT));
      checkOutput("hold_start_ready", 32'(bus.start_ready), 32'd0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    checkOutput("released_res_valid", 32'(bus.res_valid), 32'd0);

`ifdef SHIFTCOMP_SEQ_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus(8'h01, 8'h03, MAX_CYCLES, ST_TIMEOUT);
    waitValid(n);
    checkOutput("timeout_latency", 32'(n), 32'(MAX_CYCLES + 1));
`else
    $display("[TB] no match, abort at count 20");
    applyStimulus(8'h01, 8'h03, 20, ST_ABORT);
    repeat (21) @(negedge clk);
    checkOutput("no_result_before_abort", 32'(bus.res_valid), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    waitValid(n);
`endif
    @(negedge clk);

    $display("[TB] limit and abort together");
    applyStimulus(8'h01, 8'h04, 2, ST_HIT);
    abortAt(2);
    waitValid(n);
    @(negedge clk);

    $display("[TB] reset during RUN");
    sendCmd(8'h01, 8'h08);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("start_ready_after_midreset", 32'(bus.start_ready), 32'd1);
    @(negedge clk);

    $display("[TB] fresh command after reset");
    applyStimulus(8'h80, 8'h02, 2, ST_HIT);
    waitValid(n);
    checkOutput("fresh_latency", 32'(n), 32'd4);
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", total, fails);
    $finish;
  end

endmodule
